// File: rtl/serial_word_transmitter_pkg.sv
// Shared types and constants for the serial word transmitter.
// Holds the FSM state encoding, the dir encodings and the reset values.
package serial_word_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    localparam tx_state_t RST_STATE = ST_IDLE;
    localparam logic      RST_BIT   = 1'b0;

    // Bits needed to hold 0..max_value, never less than one.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/serial_tx_bit_counter.sv
// Up-counter with synchronous clear and a terminal-count flag.
// Used for both the frame bit index and the inter-frame gap.
module serial_tx_bit_counter
    import serial_word_transmitter_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] terminal,
    output logic [CW-1:0] count,
    output logic          at_terminal
);

    assign at_terminal = (count == terminal);

    // Holds at the terminal value rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_terminal) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out word transmitter with frame strobes and an idle gap.
// Optional even-parity bit after the data bits: define SERIAL_TX_PARITY_EN.
module serial_word_transmitter
    import serial_word_transmitter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dir,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam int BIT_CW = count_width(WIDTH);
    localparam int GAP_CW = count_width((GAP > 0) ? GAP - 1 : 0);

    localparam logic [BIT_CW-1:0] LAST_IDX     = BIT_CW'(FRAME_LEN - 1);
    localparam logic [BIT_CW-1:0] PRE_LAST_IDX = BIT_CW'(FRAME_LEN - 2);
    localparam logic [GAP_CW-1:0] GAP_LAST     = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic              HAS_GAP      = (GAP > 0);

`ifdef SERIAL_TX_PARITY_EN
    localparam logic [BIT_CW-1:0] LAST_DATA_IDX = BIT_CW'(WIDTH - 1);
    logic parity_reg;
`endif

    tx_state_t         state;
    logic [WIDTH-1:0]  shift_reg;
    logic              dir_reg;
    logic              next_bit;
    logic              accept;

    logic [BIT_CW-1:0] bit_cnt;
    logic              bit_done;
    logic              bit_clear;
    logic              bit_inc;

    logic [GAP_CW-1:0] gap_cnt;
    logic              gap_done;
    logic              gap_clear;
    logic              gap_inc;

    assign accept   = (state == ST_IDLE) && in_ready && in_valid;
    assign next_bit = (dir_reg == DIR_MSB_FIRST) ? shift_reg[WIDTH-1] : shift_reg[0];

    serial_tx_bit_counter #(.CW(BIT_CW)) u_bit_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (bit_clear),
        .enable      (bit_inc),
        .terminal    (LAST_IDX),
        .count       (bit_cnt),
        .at_terminal (bit_done)
    );

    serial_tx_bit_counter #(.CW(GAP_CW)) u_gap_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (gap_clear),
        .enable      (gap_inc),
        .terminal    (GAP_LAST),
        .count       (gap_cnt),
        .at_terminal (gap_done)
    );

    // Counters clear on the same edge the FSM leaves their state.
    always_comb begin
        bit_clear = 1'b0;
        bit_inc   = 1'b0;
        gap_clear = 1'b0;
        gap_inc   = 1'b0;
        case (state)
            ST_SHIFT: begin
                if (bit_done) bit_clear = 1'b1;
                else          bit_inc   = 1'b1;
            end
            ST_GAP: begin
                if (gap_done) gap_clear = 1'b1;
                else          gap_inc   = 1'b1;
            end
            default: ;
        endcase
    end

    // The first bit is driven from data_in directly on the accepting edge, so
    // shift_reg is loaded already advanced by one position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RST_STATE;
            shift_reg    <= '0;
            dir_reg      <= DIR_LSB_FIRST;
            in_ready     <= RST_BIT;
            serial_out   <= RST_BIT;
            serial_valid <= RST_BIT;
            frame_start  <= RST_BIT;
            frame_end    <= RST_BIT;
            busy         <= RST_BIT;
`ifdef SERIAL_TX_PARITY_EN
            parity_reg   <= RST_BIT;
`endif
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_SHIFT;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        serial_valid <= 1'b1;
                        frame_start  <= 1'b1;
                        dir_reg      <= dir;
                        if (dir == DIR_MSB_FIRST) begin
                            serial_out <= data_in[WIDTH-1];
                            shift_reg  <= data_in << 1;
                        end else begin
                            serial_out <= data_in[0];
                            shift_reg  <= data_in >> 1;
                        end
`ifdef SERIAL_TX_PARITY_EN
                        parity_reg   <= ^data_in;
`endif
                    end else begin
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                        serial_valid <= 1'b0;
                        serial_out   <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (bit_done) begin
                        state        <= HAS_GAP ? ST_GAP : ST_IDLE;
                        serial_valid <= 1'b0;
                        serial_out   <= 1'b0;
                        busy         <= HAS_GAP;
                        in_ready     <= !HAS_GAP;
                    end else begin
                        frame_end <= (bit_cnt == PRE_LAST_IDX);
`ifdef SERIAL_TX_PARITY_EN
                        if (bit_cnt == LAST_DATA_IDX) begin
                            serial_out <= parity_reg;
                        end else begin
                            serial_out <= next_bit;
                        end
`else
                        serial_out <= next_bit;
`endif
                        if (dir_reg == DIR_MSB_FIRST) shift_reg <= shift_reg << 1;
                        else                          shift_reg <= shift_reg >> 1;
                    end
                end

                ST_GAP: begin
                    if (gap_done) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed self-checking bench for serial_word_transmitter (WIDTH=8, GAP=1).
// Parity scenarios are compiled in when SERIAL_TX_PARITY_EN is defined.
module tb_serial_word_transmitter;

    localparam int WIDTH = 8;
    localparam int GAP   = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             in_valid = 1'b0;
    logic             dir = 1'b0;
    logic             in_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_transmitter #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dir          (dir),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        data_in = 8'hFF;
        dir = 1'b0;
        repeat (2) tick();
        checks++;
        if ({in_ready, busy, serial_valid, serial_out, frame_start, frame_end} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, want 000000",
                     {in_ready, busy, serial_valid, serial_out, frame_start, frame_end});
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge: got %b, want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_msb_first();
        logic exp [9];
        exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        data_in = 8'b10101010;
        dir = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in = 8'h5C;
        dir = 1'b0;
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (serial_valid !== 1'b1 || busy !== 1'b1 || serial_out !== exp[k] ||
                frame_start !== (k == 0) || frame_end !== (k == FL - 1)) begin
                errors++;
                $display("[TB] FAIL msb_bit%0d: out=%b valid=%b start=%b end=%b, want out=%b",
                         k, serial_out, serial_valid, frame_start, frame_end, exp[k]);
            end
            tick();
        end
        checks++;
        if (serial_valid !== 1'b0 || serial_out !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL msb_gap: valid=%b out=%b busy=%b ready=%b, want 0 0 1 0",
                     serial_valid, serial_out, busy, in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL msb_idle: ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_lsb_first();
        logic exp [9];
        exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        data_in = 8'b11000001;
        dir = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dir = 1'b1;
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (serial_valid !== 1'b1 || serial_out !== exp[k] ||
                frame_start !== (k == 0) || frame_end !== (k == FL - 1)) begin
                errors++;
                $display("[TB] FAIL lsb_bit%0d: out=%b valid=%b start=%b end=%b, want out=%b",
                         k, serial_out, serial_valid, frame_start, frame_end, exp[k]);
            end
            tick();
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || serial_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lsb_idle: ready=%b busy=%b valid=%b, want 1 0 0",
                     in_ready, busy, serial_valid);
        end
    endtask

    task automatic test_back_to_back();
        data_in = 8'hFF;
        dir = 1'b0;
        in_valid = 1'b1;
        tick();
        data_in = 8'h00;
        for (int i = 0; i <= FL + GAP; i++) begin
            checks++;
            if (serial_valid !== (i < FL) || serial_out !== (i < WIDTH) ||
                in_ready !== (i == FL + GAP) || frame_start !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: valid=%b out=%b ready=%b start=%b",
                         i, serial_valid, serial_out, in_ready, frame_start);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || serial_valid !== 1'b1 || serial_out !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept: start=%b valid=%b out=%b ready=%b, want 1 1 0 0",
                     frame_start, serial_valid, serial_out, in_ready);
        end
        for (int k = 1; k < FL; k++) begin
            tick();
            checks++;
            if (serial_valid !== 1'b1 || serial_out !== 1'b0 || frame_end !== (k == FL - 1)) begin
                errors++;
                $display("[TB] FAIL b2b_second_bit%0d: valid=%b out=%b end=%b",
                         k, serial_valid, serial_out, frame_end);
            end
        end
        repeat (2) tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic exp_a5 [3];
        logic exp [9];
        exp_a5 = '{1'b1, 1'b0, 1'b1};
        exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        data_in = 8'hA5;
        dir = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (serial_valid !== 1'b1 || serial_out !== exp_a5[k]) begin
                errors++;
                $display("[TB] FAIL a5_bit%0d: out=%b valid=%b, want %b 1",
                         k, serial_out, serial_valid, exp_a5[k]);
            end
            if (k < 2) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, serial_valid, serial_out, frame_start, frame_end} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midframe_async_reset: got %b, want 000000",
                     {in_ready, busy, serial_valid, serial_out, frame_start, frame_end});
        end
        tick();
        checks++;
        if (frame_end !== 1'b0 || serial_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_no_end: end=%b valid=%b, want 0 0", frame_end, serial_valid);
        end
        rst = 1'b1;
        tick();
        data_in = 8'h3C;
        dir = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (serial_valid !== 1'b1 || serial_out !== exp[k] ||
                frame_start !== (k == 0) || frame_end !== (k == FL - 1)) begin
                errors++;
                $display("[TB] FAIL after_reset_bit%0d: out=%b valid=%b start=%b end=%b, want out=%b",
                         k, serial_out, serial_valid, frame_start, frame_end, exp[k]);
            end
            tick();
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       exp [2][9];
        words = '{8'b10110000, 8'b11000000};
        exp[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int w = 0; w < 2; w++) begin
            data_in = words[w];
            dir = 1'b1;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (serial_valid !== 1'b1 || serial_out !== exp[w][k] ||
                    frame_start !== (k == 0) || frame_end !== (k == 8)) begin
                    errors++;
                    $display("[TB] FAIL parity_w%0d_bit%0d: out=%b valid=%b start=%b end=%b, want out=%b",
                             w, k, serial_out, serial_valid, frame_start, frame_end, exp[w][k]);
                end
                tick();
            end
            tick();
            checks++;
            if (in_ready !== 1'b1 || serial_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL parity_w%0d_idle: ready=%b valid=%b, want 1 0",
                         w, in_ready, serial_valid);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
